// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the transmit symbol sequencer.
// TX_PRBS_GEN_EN selects whether mode 2 decodes to PRBS or falls back to COUNT.
package tx_seq_pkg;

  typedef enum logic [1:0] {
    MODE_TABLE = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_PRBS  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] K28_5 = 8'hBC;

  // Map the raw configuration code onto a supported mode; reserved codes run as COUNT.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_TABLE;
`ifdef TX_PRBS_GEN_EN
      2'd2:    return MODE_PRBS;
`endif
      default: return MODE_COUNT;
    endcase
  endfunction

endpackage

// File: rtl/tx_symbol_sequencer_prbs7_gen.sv
// PRBS7 (x^7+x^6+1) source producing NBYTES bytes per advance, MSB-first per byte, byte 0 in LSBs.
// Only built when TX_PRBS_GEN_EN is defined.
`ifdef TX_PRBS_GEN_EN
module prbs7_gen #(
  parameter int unsigned NBYTES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adv,
  output logic [NBYTES*8-1:0]   bits_c
);

  localparam int unsigned NB = NBYTES * 8;

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic [6:0] s;

  // Unroll NB shifts: bits_c shows the bits the current state will emit next.
  always_comb begin
    s      = lfsr_q;
    bits_c = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      bits_c[(i / 8) * 8 + 7 - (i % 8)] = s[6];
      s = {s[5:0], s[6] ^ s[5]};
    end
    lfsr_d = adv ? s : lfsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 7'h7F;
    else        lfsr_q <= lfsr_d;
  end

endmodule
`endif

// File: rtl/tx_symbol_sequencer.sv
// Per-lane symbol/K generator feeding an 8b/10b encoder: table, counter or PRBS runs, comma when idle.
// Define TX_PRBS_GEN_EN to include the PRBS7 source.
module tx_symbol_sequencer
  import tx_seq_pkg::*;
#(
  parameter int unsigned LANES     = 1,
  parameter int unsigned SEQ_DEPTH = 16,
  parameter logic [7:0]  IDLE_SYM  = K28_5
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         cfg_start,
  input  logic                         cfg_stop,
  input  logic [1:0]                   cfg_mode,
  input  logic [$clog2(SEQ_DEPTH):0]   cfg_len,
  input  logic                         cfg_loop,
  input  logic                         wr_en,
  input  logic [$clog2(SEQ_DEPTH)-1:0] wr_addr,
  input  logic [LANES*9-1:0]           wr_data,
  input  logic                         out_ready,
  output logic [LANES*8-1:0]           i_8b,
  output logic [LANES-1:0]             K,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned AW = $clog2(SEQ_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = LANES * 8;
  localparam int unsigned EW = LANES * 9;

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d, sel_mode_c;
  logic [AW-1:0]   last_q, last_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            loop_q, loop_d;
  logic            stop_q, stop_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [BW-1:0]   sym_q, sym_d;
  logic [LANES-1:0] k_q, k_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load_c, idle_c;
  logic [EW-1:0]   ent_c;
  logic [EW-1:0]   tbl_q [SEQ_DEPTH];

`ifdef TX_PRBS_GEN_EN
  logic            prbs_adv_c;
  logic [BW-1:0]   prbs_c;

  prbs7_gen #(.NBYTES(LANES)) u_prbs (
    .clk    (CLK),
    .rst_n  (reset),
    .adv    (prbs_adv_c),
    .bits_c (prbs_c)
  );
`endif

  // Table storage is not reset; writes are blocked while a run is active.
  always_ff @(posedge CLK) begin
    if (wr_en && !busy_q) tbl_q[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    last_d     = last_q;
    idx_d      = idx_q;
    loop_d     = loop_q;
    stop_d     = stop_q;
    cnt_d      = cnt_q;
    sym_d      = sym_q;
    k_d        = k_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    load_c     = 1'b0;
    idle_c     = 1'b0;
    ent_c      = '0;
    sel_mode_c = mode_q;
`ifdef TX_PRBS_GEN_EN
    prbs_adv_c = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        idle_c = 1'b1;
        if (cfg_start) begin
          state_d    = RUN;
          mode_d     = decode_mode(cfg_mode);
          sel_mode_c = mode_d;
          loop_d     = cfg_loop;
          stop_d     = 1'b0;
          idx_d      = '0;
          last_d     = (cfg_len == '0 || cfg_len > LW'(SEQ_DEPTH)) ? AW'(SEQ_DEPTH - 1)
                                                                  : AW'(cfg_len - LW'(1));
          load_c     = 1'b1;
          idle_c     = 1'b0;
        end
      end
      RUN: begin
        if (cfg_stop) stop_d = 1'b1;
        if (valid_q && out_ready) begin
          if ((idx_q == last_q && !loop_q) || cfg_stop || stop_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            idle_c  = 1'b1;
          end else begin
            idx_d  = (idx_q == last_q) ? '0 : idx_q + AW'(1);
            load_c = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idle_c  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        idle_c  = 1'b1;
      end
    endcase

    if (idle_c) begin
      sym_d   = {LANES{IDLE_SYM}};
      k_d     = '1;
      valid_d = 1'b1;
    end

    // Fetch the next run symbol into the output register.
    if (load_c) begin
      valid_d = 1'b1;
      case (sel_mode_c)
        MODE_TABLE: begin
          ent_c = tbl_q[idx_d];
          for (int unsigned l = 0; l < LANES; l++) begin
            sym_d[l*8 +: 8] = ent_c[l*9 +: 8];
            k_d[l]          = ent_c[l*9 + 8];
          end
        end
`ifdef TX_PRBS_GEN_EN
        MODE_PRBS: begin
          sym_d      = prbs_c;
          k_d        = '0;
          prbs_adv_c = 1'b1;
        end
`endif
        default: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            sym_d[l*8 +: 8] = cnt_q + 8'(l);
          end
          k_d   = '0;
          cnt_d = cnt_q + 8'(LANES);
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_TABLE;
      last_q  <= '0;
      idx_q   <= '0;
      loop_q  <= 1'b0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      sym_q   <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign i_8b      = sym_q;
  assign K         = k_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tx_symbol_sequencer.sv
// Directed bench: one- and two-lane sequencers driven from a shared control stream.
module tb_tx_symbol_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_start, cfg_stop, cfg_loop, wr_en, out_ready;
  logic [1:0]  cfg_mode;
  logic [4:0]  cfg_len;
  logic [3:0]  wr_addr;
  logic [8:0]  wr_data1;
  logic [17:0] wr_data2;
  logic [7:0]  o1;
  logic [0:0]  k1;
  logic        v1, b1, d1;
  logic [15:0] o2;
  logic [1:0]  k2;
  logic        v2, b2, d2;

  assign wr_data2 = {wr_data1, wr_data1};

  tx_symbol_sequencer #(.LANES(1), .SEQ_DEPTH(16)) u_d1 (
    .CLK(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data1), .out_ready(out_ready),
    .i_8b(o1), .K(k1), .out_valid(v1), .busy(b1), .done(d1));

  tx_symbol_sequencer #(.LANES(2), .SEQ_DEPTH(16)) u_d2 (
    .CLK(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data2), .out_ready(out_ready),
    .i_8b(o2), .K(k2), .out_valid(v2), .busy(b2), .done(d2));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic [7:0] b, input logic k, input logic dn);
    chk({tag, "_byte"}, 32'(o1), 32'(b));
    chk({tag, "_k"}, 32'(k1), 32'(k));
    chk({tag, "_valid"}, 32'(v1), 32'd1);
    chk({tag, "_done"}, 32'(d1), 32'(dn));
  endtask

  task automatic chk2(input string tag, input logic [15:0] b, input logic [1:0] k, input logic dn);
    chk({tag, "_byte2"}, 32'(o2), 32'(b));
    chk({tag, "_k2"}, 32'(k2), 32'(k));
    chk({tag, "_done2"}, 32'(d2), 32'(dn));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef TX_PRBS_GEN_EN
  // Reference PRBS7: emit s[6] first, feedback s[6]^s[5], eight bits per byte.
  function automatic logic [7:0] prbs_byte(input logic [6:0] s_in, output logic [6:0] s_out);
    logic [7:0] b;
    logic [6:0] s;
    s = s_in;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b = {b[6:0], s[6]};
      s = {s[5:0], s[6] ^ s[5]};
    end
    s_out = s;
    return b;
  endfunction
  logic [6:0] m1, m2;
  logic [7:0] e0, e1, ea;
`endif

  initial begin
    reset = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_mode = 2'd0; cfg_len = 5'd0;
    cfg_loop = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data1 = 9'd0; out_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_byte", 32'(o1), 32'd0);
    chk("rst_k", 32'(k1), 32'd0);
    chk("rst_valid", 32'(v1), 32'd0);
    chk("rst_busy", 32'(b1), 32'd0);
    chk("rst_done", 32'(d1), 32'd0);
    chk("rst_byte2", 32'(o2), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    chk1("idle", 8'hBC, 1'b1, 1'b0);
    chk2("idle", 16'hBCBC, 2'b11, 1'b0);

    // Table load then one-shot TABLE run of length 3
    wr_en = 1'b1; wr_addr = 4'd0; wr_data1 = 9'h021; tick();
    wr_addr = 4'd1; wr_data1 = 9'h04A; tick();
    wr_addr = 4'd2; wr_data1 = 9'h15C; tick();
    wr_en = 1'b0;
    cfg_mode = 2'd0; cfg_len = 5'd3; cfg_loop = 1'b0; cfg_start = 1'b1; tick();
    cfg_start = 1'b0;
    chk1("t2_s0", 8'h21, 1'b0, 1'b0);
    chk("t2_busy", 32'(b1), 32'd1);
    tick(); chk1("t2_s1", 8'h4A, 1'b0, 1'b0);
    tick(); chk1("t2_s2", 8'h5C, 1'b1, 1'b0);
    chk2("t2_s2", 16'h5C5C, 2'b11, 1'b0);
    tick(); chk1("t2_end", 8'hBC, 1'b1, 1'b1);
    chk("t2_busy0", 32'(b1), 32'd0);
    tick(); chk1("t2_idle", 8'hBC, 1'b1, 1'b0);

    // COUNT run with two cycles of back-pressure
    cfg_mode = 2'd1; cfg_len = 5'd4; cfg_start = 1'b1; tick();
    cfg_start = 1'b0;
    chk2("t3_s0", 16'h0100, 2'b00, 1'b0);
    chk1("t3_l1_s0", 8'h00, 1'b0, 1'b0);
    tick(); chk2("t3_s1", 16'h0302, 2'b00, 1'b0);
    out_ready = 1'b0;
    tick(); chk2("t3_hold0", 16'h0302, 2'b00, 1'b0);
    tick(); chk2("t3_hold1", 16'h0302, 2'b00, 1'b0);
    chk1("t3_l1_hold", 8'h01, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick(); chk2("t3_s2", 16'h0504, 2'b00, 1'b0);
    tick(); chk2("t3_s3", 16'h0706, 2'b00, 1'b0);
    chk1("t3_l1_s3", 8'h03, 1'b0, 1'b0);
    tick(); chk2("t3_end", 16'hBCBC, 2'b11, 1'b1);
    tick();

    // Looped TABLE run; start+stop together, ignored start and write while busy
    cfg_mode = 2'd0; cfg_len = 5'd2; cfg_loop = 1'b1; cfg_start = 1'b1; cfg_stop = 1'b1; tick();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    chk1("t4_s0", 8'h21, 1'b0, 1'b0);
    tick(); chk1("t4_s1", 8'h4A, 1'b0, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data1 = 9'h0FF; cfg_start = 1'b1;
    tick(); wr_en = 1'b0; cfg_start = 1'b0;
    chk1("t4_s2", 8'h21, 1'b0, 1'b0);
    tick(); chk1("t4_s3", 8'h4A, 1'b0, 1'b0);
    tick(); chk1("t4_s4", 8'h21, 1'b0, 1'b0);
    cfg_stop = 1'b1;
    tick(); cfg_stop = 1'b0;
    chk1("t4_end", 8'hBC, 1'b1, 1'b1);
    tick(); chk1("t4_idle", 8'hBC, 1'b1, 1'b0);

`ifdef TX_PRBS_GEN_EN
    // PRBS looped over 128 symbols, then stop
    m1 = 7'h7F; m2 = 7'h7F;
    cfg_mode = 2'd2; cfg_len = 5'd0; cfg_loop = 1'b1; cfg_start = 1'b1; tick();
    cfg_start = 1'b0;
    chk("t5_first", 32'(o1), 32'h0FE);
    for (int i = 0; i < 128; i++) begin
      ea = prbs_byte(m1, m1);
      e0 = prbs_byte(m2, m2);
      e1 = prbs_byte(m2, m2);
      chk1($sformatf("t5_s%0d", i), ea, 1'b0, 1'b0);
      chk2($sformatf("t5_s%0d", i), {e1, e0}, 2'b00, 1'b0);
      if (i == 127) begin
        chk("t5_period", 32'(o1), 32'h0FE);
        cfg_stop = 1'b1;
      end
      tick();
    end
    cfg_stop = 1'b0;
    chk1("t5_end", 8'hBC, 1'b1, 1'b1);
`else
    // Mode 2 without PRBS support runs as COUNT; len 0 means 16 symbols
    cfg_mode = 2'd2; cfg_len = 5'd0; cfg_loop = 1'b0; cfg_start = 1'b1; tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk1($sformatf("t5_s%0d", i), 8'(4 + i), 1'b0, 1'b0);
      chk2($sformatf("t5_s%0d", i), {8'(9 + 2 * i), 8'(8 + 2 * i)}, 2'b00, 1'b0);
      tick();
    end
    chk1("t5_end", 8'hBC, 1'b1, 1'b1);
`endif
    tick();

    // Asynchronous reset in the middle of a run
    cfg_mode = 2'd1; cfg_len = 5'd8; cfg_loop = 1'b0; cfg_start = 1'b1; tick();
    cfg_start = 1'b0;
    tick();
    #3 reset = 1'b0;
    #1;
    chk("t6_byte", 32'(o1), 32'd0);
    chk("t6_k", 32'(k1), 32'd0);
    chk("t6_valid", 32'(v1), 32'd0);
    chk("t6_busy", 32'(b1), 32'd0);
    chk("t6_done", 32'(d1), 32'd0);
    chk("t6_byte2", 32'(o2), 32'd0);
    tick();
    chk("t6_done_hold", 32'(d1), 32'd0);
    reset = 1'b1;
    tick(); chk1("t6_idle", 8'hBC, 1'b1, 1'b0);
    cfg_len = 5'd1; cfg_start = 1'b1; tick();
    cfg_start = 1'b0;
    chk1("t6_cnt0", 8'h00, 1'b0, 1'b0);
    tick(); chk1("t6_end", 8'hBC, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
